// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT datapath: default modulus, butterfly
// mode encoding and the modular halving rule used for INTT scaling.
package ntt_pkg;

  localparam int unsigned WIDTH_DEFAULT = 23;
  localparam int unsigned Q_DEFAULT     = 8380417;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  // x * 2^-1 mod q for x < q (q odd): an odd x becomes even once q is added.
  function automatic logic [31:0] mod_half(input logic [31:0] x, input logic [31:0] q);
    logic [32:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return 32'(s >> 1);
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Pipelined modular multiplier: full product in the first stage, Barrett
// reduction after it, remaining stages are pure delay. Freezes when en_i is low.
module mod_mul
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned Q      = Q_DEFAULT,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] w_i,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned   PW = 2 * WIDTH;
  localparam logic [PW:0]   QP = (PW+1)'(Q);
  // floor(4^WIDTH / Q): the quotient estimate is at most one short, so one
  // conditional subtraction finishes the reduction.
  localparam logic [PW:0]   MU = ((PW+1)'(1) << PW) / QP;

  logic [PW-1:0]   prod_q;
  logic [2*PW:0]   qm;
  logic [PW:0]     q_est;
  logic [PW:0]     r_wide;
  logic [WIDTH-1:0] red;

  // NOTE: datapath registers carry no reset; only the valid bits alongside them
  // decide whether their contents mean anything.
  always_ff @(posedge clk_i) begin
    if (en_i) prod_q <= PW'(x_i) * PW'(w_i);
  end

  assign qm     = (2*PW+1)'(prod_q) * (2*PW+1)'(MU);
  assign q_est  = (PW+1)'(qm >> PW);
  assign r_wide = {1'b0, prod_q} - q_est * QP;
  assign red    = (r_wide >= QP) ? WIDTH'(r_wide - QP) : WIDTH'(r_wide);

  generate
    if (STAGES == 1) begin : g_direct
      assign p_o = red;
    end else begin : g_delay
      logic [WIDTH-1:0] d_q [STAGES-1];
      always_ff @(posedge clk_i) begin
        if (en_i) begin
          d_q[0] <= red;
          for (int i = 1; i < int'(STAGES) - 1; i++) d_q[i] <= d_q[i-1];
        end
      end
      assign p_o = d_q[STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Pipelined CT/GS modular butterfly with optional halving and a pass-through
// tag; pre-add stage, shared modular multiplier, post-add/output stage.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned Q     = Q_DEFAULT,
  parameter int unsigned LAT   = 4,
  parameter int unsigned TAGW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] twiddle_i,
  input  bf_mode_e         mode_i,
  input  logic             halve_i,
  input  logic [TAGW-1:0]  tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [TAGW-1:0]  tag_o
);

  localparam int unsigned    MSTG = LAT - 2;
  localparam logic [WIDTH:0] QE   = (WIDTH+1)'(Q);

  typedef struct packed {
    logic             valid;
    bf_mode_e         mode;
    logic             halve;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] sum;
  } meta_t;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QE) ? WIDTH'(s - QE) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[WIDTH] ? WIDTH'(d + QE) : WIDTH'(d);
  endfunction

  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
    return WIDTH'(mod_half(32'(x), Q));
  endfunction

  logic             en;
  meta_t            meta_q [MSTG+1];
  meta_t            m;
  logic [WIDTH-1:0] mul_x_q, mul_w_q, mul_res;
  logic [WIDTH-1:0] res_a, res_b;

  // The whole pipe advances together; a full output register that is not
  // being drained freezes every stage behind it.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= int'(MSTG); i++) meta_q[i].valid <= 1'b0;
    end else if (en) begin
      meta_q[0] <= '{valid: in_valid_i, mode: mode_i, halve: halve_i,
                     tag: tag_i, a: a_i, sum: add_mod(a_i, b_i)};
      mul_x_q   <= (mode_i == BF_GS) ? sub_mod(a_i, b_i) : b_i;
      mul_w_q   <= twiddle_i;
      for (int i = 1; i <= int'(MSTG); i++) meta_q[i] <= meta_q[i-1];
    end
  end

  mod_mul #(
    .WIDTH  (WIDTH),
    .Q      (Q),
    .STAGES (MSTG)
  ) u_mod_mul (
    .clk_i (clk_i),
    .en_i  (en),
    .x_i   (mul_x_q),
    .w_i   (mul_w_q),
    .p_o   (mul_res)
  );

  assign m = meta_q[MSTG];

  always_comb begin
    res_a = m.sum;
    res_b = mul_res;
    if (m.mode == BF_CT) begin
      res_a = add_mod(m.a, mul_res);
      res_b = sub_mod(m.a, mul_res);
    end
    if (m.halve) begin
      res_a = half(res_a);
      res_b = half(res_b);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      tag_o       <= '0;
    end else if (en) begin
      out_valid_o <= m.valid;
      a_o         <= res_a;
      b_o         <= res_b;
      tag_o       <= m.tag;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Self-checking bench for ntt_butterfly_pipe: directed vector table, stalled
// stream, mixed random stream and mid-flight reset, all via a scoreboard.
module tb_ntt_butterfly_pipe;
  import ntt_pkg::*;

  localparam int unsigned WIDTH = 23;
  localparam int unsigned Q     = 8380417;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TAGW  = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i, b_i, twiddle_i;
  bf_mode_e         mode_i;
  logic             halve_i;
  logic [TAGW-1:0]  tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] a_o, b_o;
  logic [TAGW-1:0]  tag_o;

  ntt_butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .twiddle_i   (twiddle_i),
    .mode_i      (mode_i),
    .halve_i     (halve_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .a_o         (a_o),
    .b_o         (b_o),
    .tag_o       (tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic [TAGW-1:0]  tag;
    int               cyc;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a, b, w;
    bf_mode_e         mode;
    logic             halve;
    logic [WIDTH-1:0] ea, eb;
  } vec_t;

  exp_t             sb[$];
  exp_t             mon_e;
  vec_t             tbl[7];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  bit               lat_chk = 1'b0;
  bit               rnd_ready = 1'b0;
  logic [WIDTH-1:0] pend_a, pend_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input longint unsigned a, input longint unsigned b,
                                input longint unsigned w, input bf_mode_e m, input bit h,
                                output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
    longint unsigned ra, rb, t;
    if (m == BF_CT) begin
      t  = (b * w) % Q;
      ra = (a + t) % Q;
      rb = (a + Q - t) % Q;
    end else begin
      ra = (a + b) % Q;
      rb = (((a + Q - b) % Q) * w) % Q;
    end
    if (h) begin
      ra = ra[0] ? (ra + Q) / 2 : ra / 2;
      rb = rb[0] ? (rb + Q) / 2 : rb / 2;
    end
    ea = WIDTH'(ra);
    eb = WIDTH'(rb);
  endfunction

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    if (rnd_ready) begin
      #1;
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: tag %0d emitted with empty scoreboard (t=%0t)", tag_o, $time);
        end else begin
          mon_e = sb.pop_front();
          check("result_a", a_o, mon_e.a);
          check("result_b", b_o, mon_e.b);
          check("result_tag", tag_o, mon_e.tag);
          if (lat_chk) check("latency", 64'(cyc - mon_e.cyc), LAT);
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back('{a: pend_a, b: pend_b, tag: tag_i, cyc: cyc});
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] w, input bf_mode_e m, input logic h,
                      input logic [TAGW-1:0] t, input logic [WIDTH-1:0] ea,
                      input logic [WIDTH-1:0] eb);
    int n = 0;
    a_i = a; b_i = b; twiddle_i = w; mode_i = m; halve_i = h; tag_i = t;
    pend_a = ea; pend_b = eb;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] w, input bf_mode_e m, input logic h,
                            input logic [TAGW-1:0] t);
    logic [WIDTH-1:0] ea, eb;
    model(a, b, w, m, h, ea, eb);
    send(a, b, w, m, h, t, ea, eb);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(sb.size()), 0);
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'($urandom_range(0, Q - 1));
  endfunction

  initial begin
    tbl[0] = '{a: 1,       b: 2,       w: 3,       mode: BF_CT, halve: 0, ea: 7,       eb: 8380412};
    tbl[1] = '{a: 5,       b: 3,       w: 10,      mode: BF_GS, halve: 0, ea: 8,       eb: 20};
    tbl[2] = '{a: 3,       b: 0,       w: 1,       mode: BF_GS, halve: 1, ea: 4190210, eb: 4190210};
    tbl[3] = '{a: 8380416, b: 1,       w: 1,       mode: BF_CT, halve: 0, ea: 0,       eb: 8380415};
    tbl[4] = '{a: 0,       b: 1,       w: 1,       mode: BF_GS, halve: 0, ea: 1,       eb: 8380416};
    tbl[5] = '{a: 8380416, b: 8380416, w: 8380416, mode: BF_CT, halve: 1, ea: 0,       eb: 8380416};
    tbl[6] = '{a: 10,      b: 20,      w: 2,       mode: BF_GS, halve: 0, ea: 30,      eb: 8380397};

    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; twiddle_i = '0; mode_i = BF_CT; halve_i = 1'b0; tag_i = '0;
    pend_a = '0; pend_b = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("reset_out_valid", out_valid_o, 0);
    check("reset_a_o", a_o, 0);
    check("reset_b_o", b_o, 0);
    check("reset_tag_o", tag_o, 0);
    check("reset_in_ready", in_ready_o, 1);

    // Directed vectors, one at a time so latency is exact.
    lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].mode, tbl[i].halve, TAGW'(i),
           tbl[i].ea, tbl[i].eb);
      drain();
    end

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send_model(rnd(), rnd(), rnd(), BF_CT, 1'b0, TAGW'(8'h10 + i));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_a_o", a_o, 0);
    check("midrst_b_o", b_o, 0);
    check("midrst_tag_o", tag_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    begin
      int stale = 0;
      repeat (12) begin
        @(negedge clk_i);
        if (out_valid_o) stale++;
      end
      check("stale_after_reset", 64'(stale), 0);
    end
    send(5, 3, 10, BF_GS, 1'b0, 8'h20, 8, 20);
    drain();
    lat_chk = 1'b0;

    // Back-to-back CT stream with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(rnd(), rnd(), rnd(), BF_CT, 1'b0, TAGW'(i));
      end
      begin
        int n = 0;
        logic [WIDTH-1:0] ha, hb;
        logic [TAGW-1:0]  ht;
        while (!out_valid_o && n < 50) begin
          @(posedge clk_i); #1;
          n++;
        end
        if (n >= 50) check("stall_wait_timeout", out_valid_o, 1);
        out_ready_i = 1'b0;
        ha = a_o; hb = b_o; ht = tag_o;
        check("stall_first_tag", ht, 0);
        repeat (3) begin
          @(negedge clk_i);
          check("stall_in_ready", in_ready_o, 0);
          check("stall_a_stable", a_o, ha);
          check("stall_b_stable", b_o, hb);
          check("stall_tag_stable", tag_o, ht);
          @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Mixed CT/GS stream, halve toggling, random input gaps and backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
      send_model(rnd(), rnd(), rnd(), (i % 2 == 1) ? BF_GS : BF_CT, 1'(i % 3 == 1 || i % 3 == 2 ? (i / 1) % 2 : (i % 2)), TAGW'(8'h40 + i));
    end
    rnd_ready = 1'b0;
    @(posedge clk_i); #2;
    out_ready_i = 1'b1;
    drain();
    check("final_scoreboard_empty", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
